// File: rtl/iir_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// iir_coeff_ctrl
//   Coefficient configuration controller for the biquad IIR notch stage.
//   The host fills a shadow bank (B0, B1, B2, A1, A2). A commit request waits
//   for a gap in the sample stream (or a bounded timeout) and loads the whole
//   bank into the filter in one strobe. After the load the filter is held in
//   bypass for a programmable number of samples to hide the recursion
//   transient.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   valid_in     : sample strobe of the IIR datapath
//   cfg_wr_en    : shadow write strobe (cfg_addr, cfg_wdata)
//   cfg_rd_en    : read strobe, data returned one cycle later
//   cfg_addr     : 0..4 shadow bank, 8..12 live filter bank
//   cfg_wdata    : signed Q2.18 write data
//   cfg_commit   : commit shadow bank to the filter
//   cfg_bypass   : static host bypass request
//   coeff_rd     : live coefficients read back from the filter
//   coeff_wr_en  : one-cycle filter load strobe
//   coeff_wdata  : coefficient bank to the filter (the shadow bank)
//   bypass       : registered filter bypass
//   cfg_rdata    : read data
//   cfg_rvalid   : read data valid
//   cfg_busy     : commit in progress
//   cfg_err      : one-cycle error pulse
//   cfg_done     : one-cycle pulse when a commit has fully completed
// -----------------------------------------------------------------------------
module iir_coeff_ctrl #(
   parameter int COEFF_WIDTH    = 20,
   parameter int COEFF_DEPTH    = 5,
   parameter int SETTLE_SAMPLES = 4,
   parameter int MAX_WAIT       = 64
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  valid_in,
   input  logic                                  cfg_wr_en,
   input  logic                                  cfg_rd_en,
   input  logic [3:0]                            cfg_addr,
   input  logic signed [COEFF_WIDTH-1:0]         cfg_wdata,
   input  logic                                  cfg_commit,
   input  logic                                  cfg_bypass,
   input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_rd,
   output logic                                  coeff_wr_en,
   output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_wdata,
   output logic                                  bypass,
   output logic [COEFF_WIDTH-1:0]                cfg_rdata,
   output logic                                  cfg_rvalid,
   output logic                                  cfg_busy,
   output logic                                  cfg_err,
   output logic                                  cfg_done
);

   // Both banks share a 3-bit offset inside their half of the address map,
   // so the bank depth must not exceed 8.
   localparam int AW = (COEFF_DEPTH > 1) ? $clog2(COEFF_DEPTH) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   // A zero-sample settle phase still needs a legal (1-bit) counter.
   localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

   localparam logic [3:0]    DEPTH_A     = 4'(COEFF_DEPTH);
   localparam logic [WW-1:0] WAIT_LAST   = WW'(MAX_WAIT - 1);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_SAMPLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      APPLY  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   typedef struct packed {
      logic                   valid;
      logic [COEFF_WIDTH-1:0] data;
   } rd_rsp_t;

   state_t                                 state, next_state;
   logic [WW-1:0]                          wait_cnt;
   logic [SW-1:0]                          settle_cnt;
   logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow;
   rd_rsp_t                                rsp;

   logic                   shadow_hit, live_hit;
   logic [AW-1:0]          idx;
   logic [COEFF_WIDTH-1:0] rd_mux;
   logic                   wr_ok, err_set, done_set;

   // ---------------------------------------------------------------------------
   // Address decode and read mux
   // ---------------------------------------------------------------------------
   assign shadow_hit = !cfg_addr[3] && ({1'b0, cfg_addr[2:0]} < DEPTH_A);
   assign live_hit   =  cfg_addr[3] && ({1'b0, cfg_addr[2:0]} < DEPTH_A);
   assign idx        = cfg_addr[AW-1:0];

   always_comb begin
      rd_mux = '0;
      if (shadow_hit)
         rd_mux = shadow[idx];
      else if (live_hit)
         rd_mux = coeff_rd[idx];
   end

   // Writes are only accepted while no commit is in flight, so the bank the
   // filter receives is exactly what was there when the commit was taken.
   assign wr_ok = cfg_wr_en && shadow_hit && (state == IDLE);

   assign err_set = (cfg_wr_en  && !wr_ok)
                  | (cfg_rd_en  && !(shadow_hit || live_hit))
                  | (cfg_commit && (state != IDLE));

   // ---------------------------------------------------------------------------
   // FSM next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (cfg_commit)
               next_state = ARMED;
         end
         ARMED: begin
            // A quiet cycle is the sample boundary; the timeout keeps a
            // continuous stream from starving the commit.
            if (!valid_in || (wait_cnt == WAIT_LAST))
               next_state = APPLY;
         end
         APPLY: begin
            next_state = (SETTLE_SAMPLES == 0) ? IDLE : SETTLE;
         end
         SETTLE: begin
            if (valid_in && (settle_cnt <= SW'(1)))
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign done_set = ((state == APPLY) || (state == SETTLE)) && (next_state == IDLE);

   // ---------------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         state <= next_state;

         // Counts cycles spent in ARMED; cleared whenever ARMED is left, so
         // it never reaches MAX_WAIT.
         if ((state == ARMED) && (next_state == ARMED))
            wait_cnt <= wait_cnt + WW'(1);
         else
            wait_cnt <= '0;

         if (state == APPLY)
            settle_cnt <= SETTLE_INIT;
         else if ((state == SETTLE) && valid_in && (settle_cnt != '0))
            settle_cnt <= settle_cnt - SW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Shadow bank
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shadow <= '0;
      else if (wr_ok)
         shadow[idx] <= cfg_wdata;
   end

   // ---------------------------------------------------------------------------
   // Registered host-side outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp      <= '0;
         cfg_err  <= 1'b0;
         cfg_done <= 1'b0;
         bypass   <= 1'b0;
      end else begin
         // Read samples the bank before this edge's write, so a same-cycle
         // read of the written address returns the old word.
         rsp.valid <= cfg_rd_en;
         rsp.data  <= cfg_rd_en ? rd_mux : '0;
         cfg_err   <= err_set;
         cfg_done  <= done_set;
         bypass    <= cfg_bypass | (state == SETTLE);
      end
   end

   assign cfg_rvalid  = rsp.valid;
   assign cfg_rdata   = rsp.data;
   assign cfg_busy    = (state != IDLE);
   assign coeff_wr_en = (state == APPLY);
   assign coeff_wdata = shadow;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
module tb_iir_coeff_ctrl;
   localparam int W = 20;
   localparam int D = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic valid_in = 1'b0, cfg_wr_en = 1'b0, cfg_rd_en = 1'b0;
   logic cfg_commit = 1'b0, cfg_bypass = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [W-1:0] cfg_wdata = '0;

   // filter model: live bank reloads on the load strobe
   logic [D-1:0][W-1:0] live  = {20'hA0004, 20'hA0003, 20'hA0002, 20'hA0001, 20'hA0000};
   logic [D-1:0][W-1:0] live0 = {20'hB0004, 20'hB0003, 20'hB0002, 20'hB0001, 20'hB0000};

   logic coeff_wr_en, bypass, cfg_rvalid, cfg_busy, cfg_err, cfg_done;
   logic [D-1:0][W-1:0] coeff_wdata;
   logic [W-1:0] cfg_rdata;

   logic coeff_wr_en0, bypass0, cfg_rvalid0, cfg_busy0, cfg_err0, cfg_done0;
   logic [D-1:0][W-1:0] coeff_wdata0;
   logic [W-1:0] cfg_rdata0;

   iir_coeff_ctrl dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
      .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_bypass(cfg_bypass),
      .coeff_rd(live), .coeff_wr_en(coeff_wr_en), .coeff_wdata(coeff_wdata),
      .bypass(bypass), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_done(cfg_done)
   );

   iir_coeff_ctrl #(.SETTLE_SAMPLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
      .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_bypass(cfg_bypass),
      .coeff_rd(live0), .coeff_wr_en(coeff_wr_en0), .coeff_wdata(coeff_wdata0),
      .bypass(bypass0), .cfg_rdata(cfg_rdata0), .cfg_rvalid(cfg_rvalid0),
      .cfg_busy(cfg_busy0), .cfg_err(cfg_err0), .cfg_done(cfg_done0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (coeff_wr_en) live <= coeff_wdata;

   // exp packing: {coeff_wr_en, bypass, rvalid, busy, err, done, rdata}
   typedef struct {
      logic         wr, rd;
      logic [3:0]   addr;
      logic [W-1:0] wdata;
      logic         cm, by, vi;
      logic [W+5:0] exp;
   } vec_t;

   vec_t vq[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic addv(input int wr, rd, addr, wd, cm, by, vi,
                       input int ewr, eby, erv, erd, ebs, eer, edn);
      vec_t v;
      v.wr = wr[0]; v.rd = rd[0]; v.addr = 4'(addr); v.wdata = W'(wd);
      v.cm = cm[0]; v.by = by[0]; v.vi = vi[0];
      v.exp = {ewr[0], eby[0], erv[0], ebs[0], eer[0], edn[0], W'(erd)};
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      cfg_wr_en = 0; cfg_rd_en = 0; cfg_commit = 0; cfg_bypass = 0;
      cfg_addr = 0; cfg_wdata = 0; valid_in = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] dv [5];
      logic [W-1:0] fin [5];
      int n;
      dv = '{20'h37061, 20'hC8F9F, 20'h37061, 20'hC8F9F, 20'h2E0C3};

      // ---- vector table ----
      for (int i = 0; i < 5; i++) addv(0,1,i,0, 0,0,0, 0,0,1,0,0,0,0);
      for (int i = 0; i < 5; i++) addv(1,0,i,int'(dv[i]), 0,0,0, 0,0,0,0,0,0,0);
      addv(1,1,2,'h11111, 0,0,0, 0,0,1,'h37061,0,0,0);
      addv(1,1,2,'h37061, 0,0,0, 0,0,1,'h11111,0,0,0);
      addv(0,1,2,0,       0,0,0, 0,0,1,'h37061,0,0,0);
      addv(0,1,1,0,       0,0,0, 0,0,1,'hC8F9F,0,0,0);
      addv(0,1,4,0,       0,0,0, 0,0,1,'h2E0C3,0,0,0);
      addv(1,0,5,'h12345, 0,0,0, 0,0,0,0,0,1,0);
      addv(0,1,5,0,       0,0,0, 0,0,1,0,0,1,0);
      addv(0,1,15,0,      0,0,0, 0,0,1,0,0,1,0);
      addv(0,1,4,0,       0,0,0, 0,0,1,'h2E0C3,0,0,0);
      addv(0,1,8,0,       0,0,0, 0,0,1,'hA0000,0,0,0);
      addv(0,1,12,0,      0,0,0, 0,0,1,'hA0004,0,0,0);
      addv(0,1,13,0,      0,0,0, 0,0,1,0,0,1,0);
      addv(0,0,0,0,       0,1,0, 0,1,0,0,0,0,0);
      addv(0,0,0,0,       0,0,0, 0,0,0,0,0,0,0);
      // commit, then commit-while-busy and write-while-busy
      addv(0,0,0,0,       1,0,0, 0,0,0,0,1,0,0);
      addv(0,0,0,0,       1,0,0, 1,0,0,0,1,1,0);
      addv(1,1,0,'h00001, 0,0,0, 0,0,1,'h37061,1,1,0);
      addv(0,0,0,0,       0,0,1, 0,1,0,0,1,0,0);
      addv(0,0,0,0,       0,0,0, 0,1,0,0,1,0,0);
      addv(0,0,0,0,       0,0,1, 0,1,0,0,1,0,0);
      addv(0,0,0,0,       0,0,1, 0,1,0,0,1,0,0);
      addv(0,0,0,0,       0,0,1, 0,1,0,0,0,0,1);
      addv(0,1,8,0,       0,0,0, 0,0,1,'h37061,0,0,0);
      addv(0,1,11,0,      0,0,0, 0,0,1,'hC8F9F,0,0,0);
      addv(0,1,12,0,      0,0,0, 0,0,1,'h2E0C3,0,0,0);
      addv(0,1,0,0,       0,0,0, 0,0,1,'h37061,0,0,0);
      // write lands in the same cycle as the commit
      addv(1,0,4,'h00ABC, 1,0,0, 0,0,0,0,1,0,0);
      addv(0,0,0,0,       0,0,1, 0,0,0,0,1,0,0);
      addv(0,0,0,0,       0,0,0, 1,0,0,0,1,0,0);
      addv(0,1,12,0,      0,0,0, 0,0,1,'h2E0C3,1,0,0);
      for (int i = 0; i < 3; i++) addv(0,0,0,0, 0,0,1, 0,1,0,0,1,0,0);
      addv(0,0,0,0,       0,0,1, 0,1,0,0,0,0,1);
      addv(0,1,12,0,      0,0,0, 0,0,1,'h00ABC,0,0,0);
      addv(0,1,4,0,       0,0,0, 0,0,1,'h00ABC,0,0,0);

      // ---- reset ----
      clr_in();
      #22 rst_n = 1'b1;
      chk("reset_outputs", {coeff_wr_en, bypass, cfg_rvalid, cfg_busy, cfg_err, cfg_done, cfg_rdata},
          32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         cfg_wr_en = vq[i].wr; cfg_rd_en = vq[i].rd; cfg_addr = vq[i].addr;
         cfg_wdata = vq[i].wdata; cfg_commit = vq[i].cm; cfg_bypass = vq[i].by;
         valid_in = vq[i].vi;
         step();
         chk($sformatf("vec%0d", i),
             {coeff_wr_en, bypass, cfg_rvalid, cfg_busy, cfg_err, cfg_done, cfg_rdata},
             vq[i].exp);
      end
      clr_in();

      fin = '{20'h37061, 20'hC8F9F, 20'h37061, 20'hC8F9F, 20'h00ABC};
      for (int i = 0; i < D; i++) begin
         chk($sformatf("coeff_wdata[%0d]", i), coeff_wdata[i], fin[i]);
         chk($sformatf("coeff_wdata0[%0d]", i), coeff_wdata0[i], fin[i]);
      end

      // ---- forced apply under continuous valid_in ----
      valid_in = 1; cfg_commit = 1;
      step();
      cfg_commit = 0;
      n = 1;
      while (!coeff_wr_en && n < 200) begin step(); n++; end
      chk("forced_apply_cycles", n, 65);
      chk("forced_apply_dut0", coeff_wr_en0, 1);
      step();
      chk("apply_one_cycle", coeff_wr_en, 0);
      n = 0;
      do begin step(); n++; end while (cfg_busy && n < 20);
      chk("forced_settle_done", {cfg_busy, cfg_done}, 2'b01);
      valid_in = 0;
      step();

      // ---- SETTLE_SAMPLES=0 instance; dut enters SETTLE meanwhile ----
      cfg_rd_en = 1; cfg_addr = 8; cfg_commit = 1;
      step();
      cfg_rd_en = 0; cfg_commit = 0;
      chk("s0_armed", {cfg_busy0, bypass0, cfg_rvalid0, cfg_err0}, 4'b1010);
      chk("s0_live_rd", cfg_rdata0, 20'hB0000);
      step();
      chk("s0_apply", {coeff_wr_en0, cfg_busy0, bypass0, cfg_done0}, 4'b1100);
      step();
      chk("s0_done", {coeff_wr_en0, cfg_busy0, bypass0, cfg_done0}, 4'b0001);
      step();
      chk("s0_after", {coeff_wr_en0, cfg_busy0, bypass0, cfg_done0}, 4'b0000);
      chk("in_settle", {bypass, cfg_busy}, 2'b11);

      // ---- reset during SETTLE ----
      rst_n = 0;
      #1;
      chk("async_reset", {bypass, cfg_busy, coeff_wr_en, cfg_done}, 4'b0000);
      @(negedge clk);
      rst_n = 1;
      cfg_rd_en = 1; cfg_addr = 0; cfg_commit = 1;
      step();
      cfg_rd_en = 0; cfg_commit = 0;
      chk("post_reset_commit", {cfg_busy, cfg_rvalid, cfg_rdata}, {1'b1, 1'b1, 20'h0});
      step();
      chk("post_reset_apply", coeff_wr_en, 1);
      step();
      chk("post_reset_apply_end", {coeff_wr_en, cfg_busy}, 2'b01);
      valid_in = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_reset_settle%0d", i), {bypass, cfg_busy, cfg_done}, 3'b110);
      end
      step();
      chk("post_reset_done", {bypass, cfg_busy, cfg_done}, 3'b101);
      valid_in = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
